vid_pattern_gen: RTL and testbench

Parametrised video timing and test-pattern generator for the vid_clk domain. It produces DE, HSYNC and VSYNC for any CEA/VESA-style mode, plus a 3-component pixel bus. It drives the SII9136 transmitter input directly, or feeds a later mux against SII9233 pass-through video. Pattern selection and solid colour come from CPU PIO bits.

---
 rtl/vid_pattern_gen_if.sv | 13 +
 rtl/vid_pattern_gen.sv | 128 ++++++++++++
 tb/tb_vid_pattern_gen.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/vid_pattern_gen_if.sv
// rtl/vid_pattern_gen_if.sv - registered video output bus (controls, pixel, frame marker)
interface vid_pattern_gen_if #(
    parameter int COMP_W = 12
);
    logic                  de;
    logic                  hsync;
    logic                  vsync;
    logic                  frame_start;
    logic [3*COMP_W-1:0]   d;

    modport master (output de, output hsync, output vsync, output frame_start, output d);
    modport slave  (input  de, input  hsync, input  vsync, input  frame_start, input  d);
endinterface

// File: rtl/vid_pattern_gen.sv
// rtl/vid_pattern_gen.sv - video timing and test-pattern generator; VID_PATTERN_GEN_SCROLL_EN enables the scrolling split offset
module vid_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit HSYNC_POL  = 1'b1,
    parameter bit VSYNC_POL  = 1'b1,
    parameter int COMP_W     = 12,
    parameter int CNT_W      = 12,
    parameter int GRAD_SHIFT = 3
) (
    input  logic                vid_clk,
    input  logic                vid_reset_n,
    input  logic                enable,
    input  logic [1:0]          pattern_sel,
    input  logic [3*COMP_W-1:0] solid_rgb,
    vid_pattern_gen_if.master   vid
);
    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int V_TOTAL = V_BLANK + V_ACTIVE;
    localparam int BAR_W   = H_ACTIVE / 8;

    logic [CNT_W-1:0]    col;
    logic [CNT_W-1:0]    line;
    logic [CNT_W-1:0]    offset;
    logic [1:0]          pat_q;
    logic                last_col;
    logic                last_line;
    logic                frame_origin;
    logic                de_c;
    logic                hs_act;
    logic                vs_act;
    logic [CNT_W-1:0]    x;
    logic [CNT_W-1:0]    y;
    logic [2:0]          bar;
    logic [COMP_W-1:0]   x_sh;
    logic [COMP_W-1:0]   y_sh;
    logic [COMP_W-1:0]   xy_sh;
    logic [3*COMP_W-1:0] pixel;

    function automatic logic [COMP_W-1:0] shl(input logic [CNT_W-1:0] v);
        return COMP_W'({{COMP_W{1'b0}}, v} << GRAD_SHIFT);
    endfunction

    assign last_col     = (col == CNT_W'(H_TOTAL - 1));
    assign last_line    = (line == CNT_W'(V_TOTAL - 1));
    assign frame_origin = (col == '0) && (line == '0);

    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            col  <= '0;
            line <= '0;
        end else if (!enable) begin
            col  <= '0;
            line <= '0;
        end else if (last_col) begin
            col  <= '0;
            line <= last_line ? '0 : line + 1'b1;
        end else begin
            col  <= col + 1'b1;
        end
    end

    // Pattern only changes at the frame origin so a frame is never drawn with two patterns.
    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            pat_q <= 2'd0;
        end else if (!enable || frame_origin) begin
            pat_q <= pattern_sel;
        end
    end

`ifdef VID_PATTERN_GEN_SCROLL_EN
    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            offset <= '0;
        end else if (enable && last_col && last_line) begin
            offset <= (offset == CNT_W'(V_ACTIVE - 1)) ? '0 : offset + 1'b1;
        end
    end
`else
    assign offset = '0;
`endif

    assign de_c   = (col >= CNT_W'(H_BLANK)) && (line >= CNT_W'(V_BLANK));
    assign hs_act = (col >= CNT_W'(H_FRONT)) && (col < CNT_W'(H_FRONT + H_SYNC));
    assign vs_act = (line >= CNT_W'(V_FRONT)) && (line < CNT_W'(V_FRONT + V_SYNC));
    assign x      = col - CNT_W'(H_BLANK);
    assign y      = line - CNT_W'(V_BLANK);
    assign bar    = 3'(x / CNT_W'(BAR_W));
    assign x_sh   = shl(x);
    assign y_sh   = shl(y);
    assign xy_sh  = shl(x ^ y);

    always_comb begin
        pixel = '0;
        case (pat_q)
            2'd0: pixel = {{COMP_W{bar[2]}}, {COMP_W{bar[1]}}, {COMP_W{bar[0]}}};
            2'd1: pixel = {x_sh, y_sh, xy_sh};
            2'd2: pixel = (y < offset) ? {{COMP_W{1'b1}}, y_sh, x_sh}
                                       : {y_sh, {COMP_W{1'b1}}, x_sh};
            default: pixel = solid_rgb;
        endcase
    end

    always_ff @(posedge vid_clk or negedge vid_reset_n) begin
        if (!vid_reset_n) begin
            vid.de          <= 1'b0;
            vid.hsync       <= ~HSYNC_POL;
            vid.vsync       <= ~VSYNC_POL;
            vid.d           <= '0;
            vid.frame_start <= 1'b0;
        end else begin
            vid.de          <= enable && de_c;
            vid.hsync       <= (enable && hs_act) ? HSYNC_POL : ~HSYNC_POL;
            vid.vsync       <= (enable && vs_act) ? VSYNC_POL : ~VSYNC_POL;
            vid.d           <= (enable && de_c) ? pixel : '0;
            vid.frame_start <= enable && frame_origin;
        end
    end
endmodule

// File: tb/tb_vid_pattern_gen.sv
// tb/tb_vid_pattern_gen.sv - scoreboard bench for vid_pattern_gen in the 24x12 small mode
module tb_vid_pattern_gen;
    logic        vid_clk;
    logic        vid_reset_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [35:0] solid_rgb;

    int errs;
    int checks;
    logic [39:0] exp_q[$];

    vid_pattern_gen_if #(.COMP_W(12)) vid();

    vid_pattern_gen #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .COMP_W(12), .CNT_W(12), .GRAD_SHIFT(3)
    ) dut (
        .vid_clk(vid_clk),
        .vid_reset_n(vid_reset_n),
        .enable(enable),
        .pattern_sel(pattern_sel),
        .solid_rgb(solid_rgb),
        .vid(vid)
    );

    initial vid_clk = 1'b0;
    always #5 vid_clk = ~vid_clk;

    // Reference model: independent counters, pushes the expected output for every clock edge.
    int mc, ml, mpat, moff, mx, my, mb;
    logic m_de, m_hs, m_vs, m_fs;
    logic [11:0] m_r, m_g, m_b;
    always @(posedge vid_clk) begin
        if (!vid_reset_n) begin
            mc = 0; ml = 0; mpat = 0; moff = 0;
            exp_q.push_back(40'h0);
        end else begin
            m_de = enable && mc >= 8 && ml >= 4;
            m_hs = enable && mc >= 2 && mc <= 4;
            m_vs = enable && ml >= 1 && ml <= 2;
            m_fs = enable && mc == 0 && ml == 0;
            mx = mc - 8;
            my = ml - 4;
            mb = mx / 2;
            case (mpat)
                0: begin
                    m_r = mb[2] ? 12'hFFF : 12'h000;
                    m_g = mb[1] ? 12'hFFF : 12'h000;
                    m_b = mb[0] ? 12'hFFF : 12'h000;
                end
                1: begin
                    m_r = 12'(mx * 8); m_g = 12'(my * 8); m_b = 12'((mx ^ my) * 8);
                end
                2: begin
                    if (my < moff) begin
                        m_r = 12'hFFF; m_g = 12'(my * 8);
                    end else begin
                        m_r = 12'(my * 8); m_g = 12'hFFF;
                    end
                    m_b = 12'(mx * 8);
                end
                default: {m_r, m_g, m_b} = solid_rgb;
            endcase
            if (!m_de) {m_r, m_g, m_b} = 36'h0;
            exp_q.push_back({m_de, m_hs, m_vs, m_fs, m_r, m_g, m_b});
            if (!enable || (mc == 0 && ml == 0)) mpat = int'(pattern_sel);
`ifdef VID_PATTERN_GEN_SCROLL_EN
            if (enable && mc == 23 && ml == 11) moff = (moff + 1) % 8;
`endif
            if (!enable) begin
                mc = 0; ml = 0;
            end else if (mc == 23) begin
                mc = 0; ml = (ml + 1) % 12;
            end else begin
                mc = mc + 1;
            end
        end
    end

    logic [39:0] mon_e, mon_a;
    always @(negedge vid_clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {vid.de, vid.hsync, vid.vsync, vid.frame_start, vid.d};
            checks++;
            if (mon_a !== mon_e) begin
                errs++;
                $display("FAIL stream t=%0t got {de,hs,vs,fs,d}=%h expected %h", $time, mon_a, mon_e);
            end
        end
    end

    task automatic chk(input string name, input logic [39:0] got, input logic [39:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 1000; i++) begin
            @(negedge vid_clk);
            if (vid.frame_start) return;
        end
        checks++;
        errs++;
        $display("FAIL frame_start_timeout got=none expected=pulse within 1000 cycles");
    endtask

    logic [23:0] hmask;
    logic [11:0] vmask;
    int p, de_cnt;

    initial begin
        errs = 0; checks = 0;
        vid_reset_n = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 36'h0;
        #1 vid_reset_n = 1'b0;
        #1 chk("reset_async", {vid.de, vid.hsync, vid.vsync, vid.frame_start, vid.d}, 40'h0);
        repeat (3) @(negedge vid_clk);
        vid_reset_n = 1'b1;
        @(negedge vid_clk);
        enable = 1'b1;

        wait_fs();
        chk("first_frame_start", 40'(vid.frame_start), 40'h1);
        p = 0; de_cnt = 0; hmask = '0; vmask = '0;
        do begin
            if (vid.de) de_cnt++;
            if (p < 24 && vid.hsync) hmask[p] = 1'b1;
            if (p % 24 == 0 && vid.vsync) vmask[p / 24] = 1'b1;
            @(negedge vid_clk);
            p++;
        end while (!vid.frame_start && p < 2000);
        chk("frame_period", 40'(p), 40'd288);
        chk("de_per_frame", 40'(de_cnt), 40'd128);
        chk("hsync_cols", 40'(hmask), 40'h00001C);
        chk("vsync_lines", 40'(vmask), 40'h006);

        repeat (104) @(negedge vid_clk);
        chk("bars_x0", 40'(vid.d), 40'h000000000);
        @(negedge vid_clk);
        chk("bars_x1", 40'(vid.d), 40'h000000000);
        @(negedge vid_clk);
        chk("bars_x2", 40'(vid.d), 40'h000000FFF);
        @(negedge vid_clk);
        chk("bars_x3", 40'(vid.d), 40'h000000FFF);
        repeat (11) @(negedge vid_clk);
        chk("bars_x14", 40'(vid.d), 40'hFFFFFFFFF);
        @(negedge vid_clk);
        chk("bars_x15", 40'(vid.d), 40'hFFFFFFFFF);

        pattern_sel = 2'd1;
        wait_fs();
        repeat (227) @(negedge vid_clk);
        chk("grad_x3_y5", 40'(vid.d), 40'h018028030);

        pattern_sel = 2'd0;
        solid_rgb = 36'h123456789;
        wait_fs();
        repeat (144) @(negedge vid_clk);
        pattern_sel = 2'd3;
        repeat (47) @(negedge vid_clk);
        chk("bars_hold_after_sel", 40'(vid.d), 40'hFFFFFFFFF);
        wait_fs();
        repeat (104) @(negedge vid_clk);
        chk("solid_next_frame", 40'(vid.d), 40'h123456789);

        pattern_sel = 2'd2;
        wait_fs();
`ifndef VID_PATTERN_GEN_SCROLL_EN
        repeat (104) @(negedge vid_clk);
        chk("split_no_scroll", 40'(vid.d), 40'h000FFF000);
`endif
        repeat (9) wait_fs();

        wait_fs();
        repeat (178) @(negedge vid_clk);
        chk("pre_drop_de", 40'(vid.de), 40'h1);
        enable = 1'b0;
        @(negedge vid_clk);
        chk("drop_outputs", {vid.de, vid.hsync, vid.vsync, vid.frame_start, vid.d}, 40'h0);
        pattern_sel = 2'd1;
        repeat (5) @(negedge vid_clk);
        enable = 1'b1;
        @(negedge vid_clk);
        chk("reenable_fs", 40'(vid.frame_start), 40'h1);

        repeat (227) @(negedge vid_clk);
        chk("grad_before_reset", 40'(vid.d), 40'h018028030);
        #2 vid_reset_n = 1'b0;
        #1 chk("reset_midframe", {vid.de, vid.hsync, vid.vsync, vid.frame_start, vid.d}, 40'h0);
        @(negedge vid_clk);
        vid_reset_n = 1'b1;
        wait_fs();
        repeat (30) @(negedge vid_clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
